// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 16-bit, 16-register core.
// Latency: stall/flush/redirect outputs are combinational in the current cycle; fwd_a/fwd_b are registered, one cycle.
// Backpressure: holds PC and IF/ID for one cycle on load-use; flushes IF/ID and ID/EXE for BRANCH_PENALTY cycles on redirect.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   id_*              source registers and use flags of the instruction in ID
//   ex_*              bundle leaving the ID/EXE register (dest, load, branch, jal)
//   mem_*             destination of the instruction in EXE/MEM
//   pc_stall, if_id_stall, if_id_flush, id_exe_flush, pc_redirect   pipeline control
//   fwd_a, fwd_b      operand selects for EX: 00 regfile, 01 EXE/MEM, 10 MEM/WB
//
// Optional build macro HAZARD_PERF_EN adds saturating stall_cnt / flush_cnt outputs.

module hazard_ctrl #(
   parameter int BRANCH_PENALTY = 2,
   parameter bit R0_HARDWIRED   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] id_rs1,
   input  logic [3:0] id_rs2,
   input  logic       id_rs1_used,
   input  logic       id_rs2_used,
   input  logic       ex_reg_wen,
   input  logic [3:0] ex_reg_waddr,
   input  logic       ex_mem_ren,
   input  logic       ex_branch,
   input  logic       ex_taken,
   input  logic       ex_jal,
   input  logic       mem_reg_wen,
   input  logic [3:0] mem_reg_waddr,
   output logic       pc_stall,
   output logic       if_id_stall,
   output logic       if_id_flush,
   output logic       id_exe_flush,
   output logic       pc_redirect,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
`ifdef HAZARD_PERF_EN
   ,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      FLUSH      = 2'd2
   } state_t;

   // The redirect cycle itself is the first flush cycle, so FLUSH covers the rest.
   localparam logic [2:0] FLUSH_INIT  = 3'(BRANCH_PENALTY - 1);
   localparam bit         MULTI_FLUSH = (BRANCH_PENALTY > 1);

   state_t     state, state_nxt;
   logic [2:0] fcnt, fcnt_nxt;

   logic       redirect;
   logic       rs1_live, rs2_live;
   logic       loaduse;
   logic [1:0] fwd_a_nxt, fwd_b_nxt;

   // A source counts only if the instruction reads it and it is not a hardwired r0.
   assign rs1_live = id_rs1_used & ~(R0_HARDWIRED & (id_rs1 == 4'd0));
   assign rs2_live = id_rs2_used & ~(R0_HARDWIRED & (id_rs2 == 4'd0));

   assign redirect = (ex_branch & ex_taken) | ex_jal;

   assign loaduse = ex_mem_ren & ex_reg_wen &
                    ((rs1_live & (ex_reg_waddr == id_rs1)) |
                     (rs2_live & (ex_reg_waddr == id_rs2)));

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         fcnt  <= 3'd0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next state and Mealy control outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt    = state;
      fcnt_nxt     = fcnt;
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_exe_flush = 1'b0;
      pc_redirect  = 1'b0;

      case (state)
         RUN: begin
            // Redirect wins: the branch is older than the load-use consumer.
            if (redirect) begin
               pc_redirect  = 1'b1;
               if_id_flush  = 1'b1;
               id_exe_flush = 1'b1;
               if (MULTI_FLUSH) begin
                  state_nxt = FLUSH;
                  fcnt_nxt  = FLUSH_INIT;
               end
            end else if (loaduse) begin
               pc_stall     = 1'b1;
               if_id_stall  = 1'b1;
               id_exe_flush = 1'b1;
               state_nxt    = LOAD_STALL;
            end
         end

         LOAD_STALL: begin
            // The bubble now in EX makes loaduse meaningless here; only a redirect matters.
            state_nxt = RUN;
            if (redirect) begin
               pc_redirect  = 1'b1;
               if_id_flush  = 1'b1;
               id_exe_flush = 1'b1;
               if (MULTI_FLUSH) begin
                  state_nxt = FLUSH;
                  fcnt_nxt  = FLUSH_INIT;
               end
            end
         end

         FLUSH: begin
            // Slots in flight are wrong-path, so their redirect/loaduse are ignored.
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
            fcnt_nxt     = fcnt - 3'd1;
            if (fcnt <= 3'd1) begin
               state_nxt = RUN;
               fcnt_nxt  = 3'd0;
            end
         end

         default: begin
            state_nxt = RUN;
            fcnt_nxt  = 3'd0;
         end
      endcase

      if (rst) begin
         pc_stall     = 1'b0;
         if_id_stall  = 1'b0;
         if_id_flush  = 1'b0;
         id_exe_flush = 1'b0;
         pc_redirect  = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Forwarding selects, computed from ID and captured with ID/EXE
   // ------------------------------------------------------------------
   always_comb begin
      fwd_a_nxt = 2'b00;
      if (rs1_live) begin
         // A load in EX has no result yet; it is covered by the stall, not by forwarding.
         if (ex_reg_wen & ~ex_mem_ren & (ex_reg_waddr == id_rs1))
            fwd_a_nxt = 2'b01;
         else if (mem_reg_wen & (mem_reg_waddr == id_rs1))
            fwd_a_nxt = 2'b10;
      end

      fwd_b_nxt = 2'b00;
      if (rs2_live) begin
         if (ex_reg_wen & ~ex_mem_ren & (ex_reg_waddr == id_rs2))
            fwd_b_nxt = 2'b01;
         else if (mem_reg_wen & (mem_reg_waddr == id_rs2))
            fwd_b_nxt = 2'b10;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_a <= 2'b00;
         fwd_b <= 2'b00;
      end else if (id_exe_flush) begin
         // A bubble entering EX must not forward anything.
         fwd_a <= 2'b00;
         fwd_b <= 2'b00;
      end else begin
         fwd_a <= fwd_a_nxt;
         fwd_b <= fwd_b_nxt;
      end
   end

`ifdef HAZARD_PERF_EN
   // ------------------------------------------------------------------
   // Saturating performance counters
   // ------------------------------------------------------------------
   logic flush_evt;

   // A load-use bubble also asserts id_exe_flush, but always together with pc_stall.
   assign flush_evt = id_exe_flush & ~pc_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= 16'd0;
         flush_cnt <= 16'd0;
      end else begin
         if (pc_stall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
         if (flush_evt && flush_cnt != 16'hFFFF)
            flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with default parameters.
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
// Counter checks are compiled in only when HAZARD_PERF_EN is defined.

module tb_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic [3:0] id_rs1, id_rs2;
   logic       id_rs1_used, id_rs2_used;
   logic       ex_reg_wen;
   logic [3:0] ex_reg_waddr;
   logic       ex_mem_ren, ex_branch, ex_taken, ex_jal;
   logic       mem_reg_wen;
   logic [3:0] mem_reg_waddr;
   logic       pc_stall, if_id_stall, if_id_flush, id_exe_flush, pc_redirect;
   logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_EN
   logic [15:0] stall_cnt, flush_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   hazard_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_rs1_used   (id_rs1_used),
      .id_rs2_used   (id_rs2_used),
      .ex_reg_wen    (ex_reg_wen),
      .ex_reg_waddr  (ex_reg_waddr),
      .ex_mem_ren    (ex_mem_ren),
      .ex_branch     (ex_branch),
      .ex_taken      (ex_taken),
      .ex_jal        (ex_jal),
      .mem_reg_wen   (mem_reg_wen),
      .mem_reg_waddr (mem_reg_waddr),
      .pc_stall      (pc_stall),
      .if_id_stall   (if_id_stall),
      .if_id_flush   (if_id_flush),
      .id_exe_flush  (id_exe_flush),
      .pc_redirect   (pc_redirect),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Control outputs packed as {pc_stall, if_id_stall, if_id_flush, id_exe_flush, pc_redirect}.
   function automatic logic [15:0] ctl();
      return {11'd0, pc_stall, if_id_stall, if_id_flush, id_exe_flush, pc_redirect};
   endfunction

   task automatic clear_in();
      id_rs1 = 4'd0; id_rs2 = 4'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
      ex_reg_wen = 1'b0; ex_reg_waddr = 4'd0; ex_mem_ren = 1'b0;
      ex_branch = 1'b0; ex_taken = 1'b0; ex_jal = 1'b0;
      mem_reg_wen = 1'b0; mem_reg_waddr = 4'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      clear_in();

      // ---------------- reset state ----------------
      #3;
      check("rst_ctl", ctl(), 16'h0000);
      ex_jal = 1'b1;                      // combinational outputs gated while in reset
      #1;
      check("rst_ctl_gated", ctl(), 16'h0000);
      ex_jal = 1'b0;
      tick();
      check("rst_fwd", {12'd0, fwd_a, fwd_b}, 16'h0000);
`ifdef HAZARD_PERF_EN
      check("rst_cnt", stall_cnt | flush_cnt, 16'h0000);
`endif
      rst = 1'b0;
      tick();

      // ---------------- load-use ----------------
      ex_mem_ren = 1'b1; ex_reg_wen = 1'b1; ex_reg_waddr = 4'd3;
      id_rs1 = 4'd3; id_rs1_used = 1'b1;
      #1;
      check("lu_ctl", ctl(), 16'b11010);
      tick();
      check("lu_fwd_bubble", {14'd0, fwd_a}, 16'd0);
      mem_reg_wen = 1'b1; mem_reg_waddr = 4'd3;   // EX still looks like a load: must be ignored
      #1;
      check("lu_stall_cycle", ctl(), 16'b00000);
      tick();
      check("lu_fwd_mem", {14'd0, fwd_a}, 16'd2);
      clear_in();
      #1;
      check("lu_back_run", ctl(), 16'b00000);
`ifdef HAZARD_PERF_EN
      check("lu_stall_cnt", stall_cnt, 16'd1);
`endif

      // ---------------- EX / MEM forwarding ----------------
      ex_reg_wen = 1'b1; ex_reg_waddr = 4'd5;
      mem_reg_wen = 1'b1; mem_reg_waddr = 4'd5;
      id_rs2 = 4'd5; id_rs2_used = 1'b1;
      #1;
      check("fwd_no_stall", ctl(), 16'b00000);
      tick();
      check("fwd_b_ex", {14'd0, fwd_b}, 16'd1);
      check("fwd_a_unused", {14'd0, fwd_a}, 16'd0);
      ex_reg_wen = 1'b0;
      tick();
      check("fwd_b_mem", {14'd0, fwd_b}, 16'd2);
      id_rs2_used = 1'b0;
      tick();
      check("fwd_b_unused", {14'd0, fwd_b}, 16'd0);
      clear_in();

      // ---------------- taken branch, penalty 2 ----------------
      ex_branch = 1'b1; ex_taken = 1'b1;
      #1;
      check("br_redirect", ctl(), 16'b00111);
      tick();
      // wrong-path loaduse plus a MEM match: ignored, and nothing forwarded
      ex_mem_ren = 1'b1; ex_reg_wen = 1'b1; ex_reg_waddr = 4'd6;
      id_rs1 = 4'd6; id_rs1_used = 1'b1;
      mem_reg_wen = 1'b1; mem_reg_waddr = 4'd6;
      #1;
      check("br_flush2", ctl(), 16'b00110);
      tick();
      check("br_fwd_zero", {14'd0, fwd_a}, 16'd0);
      clear_in();
      #1;
      check("br_back_run", ctl(), 16'b00000);
`ifdef HAZARD_PERF_EN
      check("br_flush_cnt", flush_cnt, 16'd2);
`endif
      ex_branch = 1'b1; ex_taken = 1'b0;
      #1;
      check("br_not_taken", ctl(), 16'b00000);
      clear_in();
      tick();

      // ---------------- jal together with loaduse ----------------
      ex_jal = 1'b1; ex_mem_ren = 1'b1; ex_reg_wen = 1'b1; ex_reg_waddr = 4'd4;
      id_rs1 = 4'd4; id_rs1_used = 1'b1; id_rs2 = 4'd4; id_rs2_used = 1'b1;
      mem_reg_wen = 1'b1; mem_reg_waddr = 4'd4;
      #1;
      check("jal_lu_ctl", ctl(), 16'b00111);
      tick();
      check("jal_lu_fwd", {12'd0, fwd_a, fwd_b}, 16'd0);
      clear_in();
      tick();
      check("jal_back_run", ctl(), 16'b00000);

      // ---------------- register 0 ----------------
      ex_mem_ren = 1'b1; ex_reg_wen = 1'b1; ex_reg_waddr = 4'd0;
      id_rs1 = 4'd0; id_rs1_used = 1'b1;
      mem_reg_wen = 1'b1; mem_reg_waddr = 4'd0;
      #1;
      check("r0_no_stall", ctl(), 16'b00000);
      tick();
      check("r0_fwd", {14'd0, fwd_a}, 16'd0);
      clear_in();
      tick();

      // ---------------- redirect during the load-use stall ----------------
      ex_mem_ren = 1'b1; ex_reg_wen = 1'b1; ex_reg_waddr = 4'd2;
      id_rs2 = 4'd2; id_rs2_used = 1'b1;
      #1;
      check("ls_stall", ctl(), 16'b11010);
      tick();
      ex_jal = 1'b1;
      #1;
      check("ls_redirect", ctl(), 16'b00111);
      tick();
      clear_in();
      #1;
      check("ls_flush2", ctl(), 16'b00110);
      tick();
      check("ls_back_run", ctl(), 16'b00000);

      // ---------------- reset during FLUSH ----------------
      ex_branch = 1'b1; ex_taken = 1'b1;
      tick();
      clear_in();
      #1;
      check("rf_in_flush", ctl(), 16'b00110);
      #2;
      rst = 1'b1;
      #1;
      check("rf_rst_ctl", ctl(), 16'b00000);
      check("rf_rst_fwd", {12'd0, fwd_a, fwd_b}, 16'd0);
`ifdef HAZARD_PERF_EN
      check("rf_rst_stall_cnt", stall_cnt, 16'd0);
      check("rf_rst_flush_cnt", flush_cnt, 16'd0);
`endif
      #1;
      rst = 1'b0;
      // state must already be RUN: a load-use stalls instead of flushing
      ex_mem_ren = 1'b1; ex_reg_wen = 1'b1; ex_reg_waddr = 4'd7;
      id_rs1 = 4'd7; id_rs1_used = 1'b1;
      #1;
      check("rf_run_after", ctl(), 16'b11010);
      clear_in();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 16-bit, 16-register core.
- Watches the instruction decoding in ID and the bundle leaving the ID/EXE pipeline register (reg_wen, reg_waddr, mem_ren, branch, jal) plus the EXE/MEM stage.
- Drives stall/flush for PC, IF/ID and ID/EXE.
- Produces registered forwarding selects that advance in lock-step with the ID/EXE register.

Parameters:
- BRANCH_PENALTY, 2: total flush cycles after a taken branch/jal (legal 1..7).
- R0_HARDWIRED, 1: 1 = register 0 reads as zero, so it never forwards or stalls.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- id_rs1  in  4  ID source register A.
- id_rs2  in  4  ID source register B.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- ex_reg_wen  in  1  EX instruction writes a register.
- ex_reg_waddr  in  4  EX destination register.
- ex_mem_ren  in  1  EX instruction is a load.
- ex_branch  in  1  EX instruction is a conditional branch.
- ex_taken  in  1  branch condition true (valid with ex_branch).
- ex_jal  in  1  EX instruction is jal.
- mem_reg_wen  in  1  MEM instruction writes a register.
- mem_reg_waddr  in  4  MEM destination register.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold the IF/ID register.
- if_id_flush  out  1  clear the IF/ID register.
- id_exe_flush  out  1  clear the ID/EXE register (insert bubble).
- pc_redirect  out  1  PC takes the branch/jal target this cycle.
- fwd_a  out  2  registered operand A select for EX: 00 regfile, 01 EXE/MEM result, 10 MEM/WB result.
- fwd_b  out  2  registered operand B select, same encoding.

Behaviour:
- States: RUN, LOAD_STALL, FLUSH. There is a 3-bit flush counter fcnt.
- Reset: state=RUN, fcnt=0, fwd_a=fwd_b=00. All combinational outputs are 0 while rst is high.
- redirect = (ex_branch & ex_taken) | ex_jal.
- loaduse = ex_mem_ren & ex_reg_wen & ((id_rs1_used & ex_reg_waddr==id_rs1) | (id_rs2_used & ex_reg_waddr==id_rs2)).
  - When R0_HARDWIRED=1, a source of 0 never matches.
- Stall/flush outputs are combinational (Mealy) from state and inputs, with no added latency.
- RUN:
  - If redirect: pc_redirect=1, if_id_flush=1, id_exe_flush=1.
    - If BRANCH_PENALTY>1, go to FLUSH with fcnt=BRANCH_PENALTY-1; otherwise stay in RUN.
  - Else if loaduse: pc_stall=1, if_id_stall=1, id_exe_flush=1; go to LOAD_STALL.
  - Else all outputs 0.
- Priority: redirect beats loaduse, because the branch is older. When both hold, there is no stall, only the flush.
- LOAD_STALL:
  - Exactly one cycle with all outputs 0 and the loaduse check suppressed.
  - redirect is still honoured, with the same actions as in RUN.
  - Next state is RUN.
- FLUSH:
  - if_id_flush=1 and id_exe_flush=1; pc_stall=0.
  - loaduse and redirect are ignored, since flushed slots are invalid.
  - fcnt decrements each cycle; leave for RUN when fcnt==1.
- Forwarding (A shown; B identical using rs2):
  - Next value 01 if ex_reg_wen & ~ex_mem_ren & ex_reg_waddr==id_rs1.
  - Else 10 if mem_reg_wen & mem_reg_waddr==id_rs1.
  - Else 00.
  - The select is 00 when id_rs1_used=0, or when rs1==0 and R0_HARDWIRED=1.
- The forwarding registers load 00 in any cycle where id_exe_flush=1, so bubbles never forward.
- After a load-use bubble, the load sits in MEM, so the consumer picks up fwd=10.
- Reset asserted mid-stall or mid-flush returns the block to RUN immediately and asynchronously.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds two outputs, stall_cnt[15:0] and flush_cnt[15:0]:
  - stall_cnt increments each cycle pc_stall=1.
  - flush_cnt increments each cycle id_exe_flush=1 caused by a redirect or FLUSH.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Load-use: ex_mem_ren=1, ex_reg_wen=1, ex_reg_waddr=3, id_rs1=3, id_rs1_used=1 -> pc_stall=if_id_stall=id_exe_flush=1 for exactly 1 cycle, then fwd_a=10 on the following edge.
- EX forwarding: ex_reg_wen=1, ex_reg_waddr=5, mem_reg_waddr=5, mem_reg_wen=1, id_rs2=5 -> fwd_b=01 (EX priority) after the next edge; no stall.
- Taken branch, BRANCH_PENALTY=2: ex_branch=ex_taken=1 -> pc_redirect=1 for 1 cycle; if_id_flush=id_exe_flush=1 for 2 cycles; then back to RUN.
- Simultaneous jal and loaduse -> only redirect/flush, pc_stall=0, fwd_a=fwd_b=00.
- R0: R0_HARDWIRED=1, id_rs1=0, ex_reg_waddr=0 load -> no stall, fwd_a=00.
- Reset pulse during FLUSH (fcnt=1) -> all outputs 0 asynchronously; RUN after release. With HAZARD_PERF_EN, counters read 0.
